generador_tonos: RTL and testbench

Parametrised successor of the music-box tone core (`principal`). It samples an N-key keyboard, synchronises and debounces the keys, and selects the highest-priority pressed key. It then drives a glitch-free 50 % square wave `clk_out` at that note's frequency, shifted up by a selectable octave. Note changes and silence take effect only at half-period boundaries, so `clk_out` never carries a runt pulse. It sits between the keyboard pins and the speaker driver.

---
 rtl/caja_musica_pkg.sv | 37 +++
 rtl/antirrebote.sv | 49 ++++
 rtl/generador_tonos.sv | 153 +++++++++++++++
 tb/tb_generador_tonos.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/caja_musica_pkg.sv
// Shared note table, key-to-note map and FSM state type for the tone generator.
package caja_musica_pkg;

  localparam int NUM_NOTAS = 12;
  localparam int SP_W      = 17;

  // C4..B4 half-periods in 50 MHz clock cycles
  localparam logic [SP_W-1:0] SEMIPERIODO [0:NUM_NOTAS-1] = '{
    17'd95555, 17'd90192, 17'd85132, 17'd80354, 17'd75843, 17'd71586,
    17'd67569, 17'd63776, 17'd60197, 17'd56818, 17'd53629, 17'd50619
  };

  localparam logic [3:0] MAPA_NATURAL [0:6] = '{
    4'd0, 4'd2, 4'd4, 4'd5, 4'd7, 4'd9, 4'd11
  };

  typedef enum logic {
    IDLE = 1'b0,
    TONO = 1'b1
  } estado_t;

  // A 7-key board plays the natural notes; any other size maps keys to semitones
  function automatic logic [SP_W-1:0] semiperiodo_tecla(input logic [3:0] idx,
                                                        input int n_teclas);
    logic [SP_W-1:0] sp;
    sp = SEMIPERIODO[0];
    if (n_teclas == 7) begin
      if (idx < 4'd7) sp = SEMIPERIODO[MAPA_NATURAL[idx[2:0]]];
      else            sp = SEMIPERIODO[0];
    end else begin
      if (idx < 4'd12) sp = SEMIPERIODO[idx];
      else             sp = SEMIPERIODO[0];
    end
    return sp;
  endfunction

endpackage

// File: rtl/antirrebote.sv
// Key synchroniser plus debounce: the stable vector only follows the
// synchronised keys after DEB_CYCLES cycles without any change.
module antirrebote #(
  parameter int N           = 7,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 1_000_000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] teclas,
  output logic [N-1:0] estable
);

  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] CNT_MAX = DEB_W'(DEB_CYCLES - 1);

  logic [N-1:0]     sync_r [0:SYNC_STAGES-1];
  logic [N-1:0]     prev_r;
  logic [DEB_W-1:0] cnt_r;

  // Synchroniser chain for the asynchronous key levels
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= '0;
    end else begin
      sync_r[0] <= teclas;
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
    end
  end

  // Stability counter; any change restarts the window
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_r  <= '0;
      cnt_r   <= '0;
      estable <= '0;
    end else begin
      prev_r <= sync_r[SYNC_STAGES-1];
      if (sync_r[SYNC_STAGES-1] != prev_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_MAX) begin
        estable <= sync_r[SYNC_STAGES-1];
      end else begin
        cnt_r <= cnt_r + DEB_W'(1);
      end
    end
  end

endmodule

// File: rtl/generador_tonos.sv
// Keyboard tone generator: highest-priority debounced key drives a 50 % square
// wave; note changes and silence only land on half-period boundaries.
module generador_tonos
  import caja_musica_pkg::*;
#(
  parameter int N_TECLAS    = 7,
  parameter int CNT_W       = 21,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 1_000_000,
  localparam int NOTA_W     = (N_TECLAS > 1) ? $clog2(N_TECLAS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_TECLAS-1:0] teclas,
  input  logic [1:0]          octava,
  output logic                clk_out,
  output logic                activo,
  output logic [NOTA_W-1:0]   nota
);

  logic [N_TECLAS-1:0] estable_s;
  logic                hay_tecla_s;
  logic [NOTA_W-1:0]   idx_s;
  logic [SP_W-1:0]     sp_s;
  logic [SP_W-1:0]     sp_desp_s;
  logic [CNT_W-1:0]    hp_s;
  logic                fin_fase_s;

  estado_t             estado_r;
  estado_t             estado_sig_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    hp_lat_r;
  logic [CNT_W-1:0]    cnt_sig_s;
  logic [CNT_W-1:0]    hp_sig_s;
  logic [NOTA_W-1:0]   nota_sig_s;
  logic                clk_sig_s;
  logic                activo_sig_s;

  antirrebote #(
    .N           (N_TECLAS),
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_CYCLES  (DEB_CYCLES)
  ) u_antirrebote (
    .clk     (clk),
    .reset   (reset),
    .teclas  (teclas),
    .estable (estable_s)
  );

  assign hay_tecla_s = |estable_s;
  assign fin_fase_s  = (cnt_r == hp_lat_r - CNT_W'(1));

  // Priority encoder: the lowest pressed index wins
  always_comb begin
    idx_s = '0;
    for (int i = N_TECLAS - 1; i >= 0; i--) begin
      if (estable_s[i]) idx_s = NOTA_W'(i);
      else              idx_s = idx_s;
    end
  end

  // Octave-shifted half-period, never shorter than two cycles
  always_comb begin
    sp_s      = semiperiodo_tecla(4'(idx_s), N_TECLAS);
    sp_desp_s = sp_s >> octava;
    if (sp_desp_s < SP_W'(2)) hp_s = CNT_W'(2);
    else                      hp_s = CNT_W'(sp_desp_s);
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) estado_r <= IDLE;
    else        estado_r <= estado_sig_s;
  end

  // Next-state logic
  always_comb begin
    estado_sig_s = estado_r;
    case (estado_r)
      IDLE: begin
        if (hay_tecla_s) estado_sig_s = TONO;
        else             estado_sig_s = IDLE;
      end
      TONO: begin
        if (fin_fase_s && !hay_tecla_s) estado_sig_s = IDLE;
        else                            estado_sig_s = TONO;
      end
      default: estado_sig_s = IDLE;
    endcase
  end

  // Next output and datapath values; all of them are registered below
  always_comb begin
    cnt_sig_s    = cnt_r;
    hp_sig_s     = hp_lat_r;
    nota_sig_s   = nota;
    clk_sig_s    = clk_out;
    activo_sig_s = activo;
    case (estado_r)
      IDLE: begin
        cnt_sig_s = '0;
        if (hay_tecla_s) begin
          hp_sig_s     = hp_s;
          nota_sig_s   = idx_s;
          clk_sig_s    = 1'b1;
          activo_sig_s = 1'b1;
        end else begin
          clk_sig_s    = 1'b0;
          activo_sig_s = 1'b0;
        end
      end
      TONO: begin
        if (fin_fase_s) begin
          cnt_sig_s = '0;
          if (hay_tecla_s) begin
            clk_sig_s    = ~clk_out;
            hp_sig_s     = hp_s;
            nota_sig_s   = idx_s;
            activo_sig_s = 1'b1;
          end else begin
            clk_sig_s    = 1'b0;
            activo_sig_s = 1'b0;
          end
        end else begin
          cnt_sig_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        cnt_sig_s    = '0;
        clk_sig_s    = 1'b0;
        activo_sig_s = 1'b0;
      end
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r    <= '0;
      hp_lat_r <= '0;
      clk_out  <= 1'b0;
      activo   <= 1'b0;
      nota     <= '0;
    end else begin
      cnt_r    <= cnt_sig_s;
      hp_lat_r <= hp_sig_s;
      clk_out  <= clk_sig_s;
      activo   <= activo_sig_s;
      nota     <= nota_sig_s;
    end
  end

endmodule

// File: tb/tb_generador_tonos.sv
// Self-checking bench: expected phases are queued as stimulus is applied and
// matched against phases measured on clk_out.
module tb_generador_tonos;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int LAT  = SYNC + DEB;

  typedef struct {
    logic       lvl;
    int         len;
    logic [2:0] nt;
  } fase_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] teclas;
  logic [1:0] octava;
  logic       clk_out;
  logic       activo;
  logic [2:0] nota;

  int total = 0;
  int bad   = 0;

  fase_t obs_q[$];
  fase_t exp_q[$];

  logic       mon_lvl = 1'b0;
  int         mon_len = 0;
  logic       mon_act = 1'b0;
  logic [2:0] mon_nt  = 3'd0;

  generador_tonos #(
    .N_TECLAS    (7),
    .CNT_W       (21),
    .SYNC_STAGES (SYNC),
    .DEB_CYCLES  (DEB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .teclas  (teclas),
    .octava  (octava),
    .clk_out (clk_out),
    .activo  (activo),
    .nota    (nota)
  );

  always #10 clk = ~clk;

  // Phase monitor: a phase is recorded only if activo stayed high throughout
  always @(negedge clk) begin
    if (clk_out !== mon_lvl) begin
      if (mon_act) obs_q.push_back('{mon_lvl, mon_len, mon_nt});
      mon_lvl = clk_out;
      mon_len = 1;
      mon_act = activo;
      mon_nt  = nota;
    end else begin
      mon_len = mon_len + 1;
      mon_act = mon_act & activo;
    end
  end

  function automatic int hp_model(input int k, input int oct);
    int sp [7];
    int v;
    sp = '{95555, 85132, 75843, 71586, 63776, 56818, 50619};
    v = sp[k] >> oct;
    if (v < 2) v = 2;
    return v;
  endfunction

  task automatic quiet();
    reset  = 1'b0;
    teclas = 7'd0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    obs_q.delete();
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic wait_activo(input logic val, input int lim, output int n);
    n = 0;
    while (activo !== val && n < lim) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_fases(input int k, input int lim, output int n);
    n = 0;
    while (obs_q.size() < k && n < lim) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    reset  = 1'b0;
    teclas = 7'b1111111;
    octava = 2'd3;
    repeat (10) begin
      @(negedge clk);
      total++;
      if ({clk_out, activo, nota} !== 5'b00000) begin
        bad++;
        $display("FAIL reset_hold: clk_out=%0b activo=%0b nota=%0d, want 0 0 0", clk_out, activo, nota);
      end
    end
    reset = 1'b1;
    n = 0;
    while (clk_out !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n < LAT + 1 || n > LAT + 2) begin
      bad++;
      $display("FAIL reset_start_latency: got %0d cycles, want %0d..%0d", n, LAT + 1, LAT + 2);
    end
    total++;
    if (nota !== 3'd0 || activo !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_note: nota=%0d activo=%0b, want 0 1", nota, activo);
    end
  endtask

  task automatic test_single_note();
    int    n;
    int    per;
    fase_t e;
    fase_t o;
    quiet();
    octava = 2'd3;
    teclas = 7'b0100000;
    wait_activo(1'b1, 40, n);
    total++;
    if (n >= 40) begin
      bad++;
      $display("FAIL single_start: activo not high after %0d cycles", n);
    end
    exp_q.push_back('{1'b1, hp_model(5, 3), 3'd5});
    exp_q.push_back('{1'b0, hp_model(5, 3), 3'd5});
    wait_fases(2, 2 * hp_model(5, 3) + 50, n);
    per = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++;
        $display("FAIL single_phase: no phase observed, want lvl=%0b len=%0d", e.lvl, e.len);
      end else begin
        o = obs_q.pop_front();
        per += o.len;
        if (o.lvl !== e.lvl || o.len !== e.len || o.nt !== e.nt) begin
          bad++;
          $display("FAIL single_phase: got lvl=%0b len=%0d nota=%0d, want lvl=%0b len=%0d nota=%0d",
                   o.lvl, o.len, o.nt, e.lvl, e.len, e.nt);
        end
      end
    end
    total++;
    if (per * 20 !== 284080) begin
      bad++;
      $display("FAIL single_period: got %0d ns, want 284080 ns", per * 20);
    end
  endtask

  task automatic test_priority();
    int    n;
    fase_t e;
    fase_t o;
    quiet();
    octava = 2'd3;
    teclas = 7'b0100100;
    wait_activo(1'b1, 40, n);
    total++;
    if (nota !== 3'd2 || n >= 40) begin
      bad++;
      $display("FAIL prio_winner: nota=%0d after %0d cycles, want 2", nota, n);
    end
    teclas = 7'b0100000;
    exp_q.push_back('{1'b1, hp_model(2, 3), 3'd2});
    exp_q.push_back('{1'b0, hp_model(5, 3), 3'd5});
    wait_fases(2, hp_model(2, 3) + hp_model(5, 3) + 50, n);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++;
        $display("FAIL prio_phase: no phase observed, want lvl=%0b len=%0d", e.lvl, e.len);
      end else begin
        o = obs_q.pop_front();
        if (o.lvl !== e.lvl || o.len !== e.len || o.nt !== e.nt) begin
          bad++;
          $display("FAIL prio_phase: got lvl=%0b len=%0d nota=%0d, want lvl=%0b len=%0d nota=%0d",
                   o.lvl, o.len, o.nt, e.lvl, e.len, e.nt);
        end
      end
    end
  endtask

  task automatic test_bounce();
    int    n;
    fase_t e;
    fase_t o;
    quiet();
    octava = 2'd3;
    teclas = 7'b0100000;
    wait_activo(1'b1, 40, n);
    exp_q.push_back('{1'b1, hp_model(5, 3), 3'd5});
    for (int i = 0; i < 20; i++) begin
      teclas[0] = ~teclas[0];
      repeat (2) @(negedge clk);
    end
    total++;
    if (dut.estable_s !== 7'b0100000) begin
      bad++;
      $display("FAIL bounce_estable: got %b, want 0100000", dut.estable_s);
    end
    teclas[0] = 1'b1;
    wait_fases(1, hp_model(5, 3) + 50, n);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++;
        $display("FAIL bounce_phase: no phase observed, want lvl=%0b len=%0d", e.lvl, e.len);
      end else begin
        o = obs_q.pop_front();
        if (o.lvl !== e.lvl || o.len !== e.len || o.nt !== e.nt) begin
          bad++;
          $display("FAIL bounce_phase: got lvl=%0b len=%0d nota=%0d, want lvl=%0b len=%0d nota=%0d",
                   o.lvl, o.len, o.nt, e.lvl, e.len, e.nt);
        end
      end
    end
    total++;
    if (nota !== 3'd0 || clk_out !== 1'b0 || activo !== 1'b1) begin
      bad++;
      $display("FAIL bounce_settle: nota=%0d clk_out=%0b activo=%0b, want 0 0 1", nota, clk_out, activo);
    end
  endtask

  task automatic test_release();
    int    n;
    logic  hi;
    fase_t e;
    fase_t o;
    quiet();
    octava = 2'd2;
    teclas = 7'b0100000;
    wait_activo(1'b1, 40, n);
    exp_q.push_back('{1'b1, hp_model(5, 2), 3'd5});
    repeat (100) @(negedge clk);
    octava = 2'd3;
    teclas = 7'd0;
    wait_fases(1, hp_model(5, 2) + 50, n);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++;
        $display("FAIL release_phase: no phase observed, want lvl=%0b len=%0d", e.lvl, e.len);
      end else begin
        o = obs_q.pop_front();
        if (o.lvl !== e.lvl || o.len !== e.len || o.nt !== e.nt) begin
          bad++;
          $display("FAIL release_phase: got lvl=%0b len=%0d nota=%0d, want lvl=%0b len=%0d nota=%0d",
                   o.lvl, o.len, o.nt, e.lvl, e.len, e.nt);
        end
      end
    end
    hi = 1'b0;
    repeat (200) begin
      @(negedge clk);
      hi = hi | clk_out | activo;
    end
    total++;
    if (hi !== 1'b0) begin
      bad++;
      $display("FAIL release_silence: output or activo went high after release, want silence");
    end
  endtask

  task automatic test_async_reset();
    int n;
    quiet();
    octava = 2'd3;
    teclas = 7'b0100000;
    wait_activo(1'b1, 40, n);
    repeat (50) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    total++;
    if (clk_out !== 1'b0 || activo !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_out: clk_out=%0b activo=%0b, want 0 0", clk_out, activo);
    end
    total++;
    if (dut.estable_s !== 7'd0) begin
      bad++;
      $display("FAIL async_reset_estable: got %b, want 0000000", dut.estable_s);
    end
    #2 reset = 1'b1;
    n = 0;
    while (clk_out !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n < LAT + 1 || n > LAT + 2) begin
      bad++;
      $display("FAIL async_restart_latency: got %0d cycles, want %0d..%0d", n, LAT + 1, LAT + 2);
    end
    total++;
    if (nota !== 3'd5) begin
      bad++;
      $display("FAIL async_restart_note: nota=%0d, want 5", nota);
    end
  endtask

  initial begin
    reset  = 1'b0;
    teclas = 7'd0;
    octava = 2'd0;
    test_reset();
    test_single_note();
    test_priority();
    test_bounce();
    test_release();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
